// File: rtl/uart_cmd_decoder.sv
// ASCII command decoder for the UART receive byte stream: single-letter control
// pulses (R/C/M) and an "S<digits><CR|LF>" decimal preload with an idle timeout.
module uart_cmd_decoder #(
    parameter int MAX_DIGITS     = 4,
    parameter int VALUE_W        = 14,
    parameter int TIMEOUT_CYCLES = 100_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_done,
    input  logic [7:0]         rx_data,
    output logic               o_run_stop,
    output logic               o_clear,
    output logic               o_mode,
    output logic               load_valid,
    output logic [VALUE_W-1:0] load_value,
    output logic               cmd_err,
    output logic               busy
);

    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [DCNT_W-1:0] MAX_CNT  = DCNT_W'(MAX_DIGITS);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    // Lower-case command letters, index 0 = run/stop, 1 = clear, 2 = mode
    localparam logic [23:0] CMD_LC = {8'h6D, 8'h63, 8'h72};

    typedef enum logic {IDLE, SET} state_t;

    state_t               state_reg, state_next;
    logic [VALUE_W-1:0]   acc_reg, acc_next;
    logic [DCNT_W-1:0]    dcnt_reg, dcnt_next;
    logic [TMO_W-1:0]     tmo_reg, tmo_next;
    logic [2:0]           pulse_reg, pulse_next;
    logic                 load_valid_reg, load_valid_next;
    logic [VALUE_W-1:0]   load_value_reg, load_value_next;
    logic                 err_reg, err_next;

    logic [7:0] lower;
    logic [2:0] cmd_hit;
    logic       is_digit, is_eol, is_space;

    // Folding bit 5 makes letter matches case-insensitive
    assign lower    = rx_data | 8'h20;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_eol   = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign is_space = (rx_data == 8'h20);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cmd
            assign cmd_hit[gi] = (lower == CMD_LC[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        dcnt_next       = dcnt_reg;
        tmo_next        = '0;
        pulse_next      = '0;
        load_valid_next = 1'b0;
        load_value_next = load_value_reg;
        err_next        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_done) begin
                    if (|cmd_hit) begin
                        pulse_next = cmd_hit;
                    end else if (lower == 8'h73) begin
                        state_next = SET;
                        acc_next   = '0;
                        dcnt_next  = '0;
                    end else if (!(is_eol || is_space)) begin
                        err_next = 1'b1;
                    end
                end
            end
            SET: begin
                if (rx_done) begin
                    // Any byte that is not an accepted digit ends the command
                    state_next = IDLE;
                    if (is_digit && (dcnt_reg < MAX_CNT)) begin
                        state_next = SET;
                        acc_next   = acc_reg * VALUE_W'(10) + VALUE_W'(rx_data[3:0]);
                        dcnt_next  = dcnt_reg + DCNT_W'(1);
                    end else if (is_eol && (dcnt_reg != '0)) begin
                        load_valid_next = 1'b1;
                        load_value_next = acc_reg;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end else begin
                    tmo_next = tmo_reg + TMO_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            dcnt_reg       <= '0;
            tmo_reg        <= '0;
            pulse_reg      <= '0;
            load_valid_reg <= 1'b0;
            load_value_reg <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            dcnt_reg       <= dcnt_next;
            tmo_reg        <= tmo_next;
            pulse_reg      <= pulse_next;
            load_valid_reg <= load_valid_next;
            load_value_reg <= load_value_next;
            err_reg        <= err_next;
        end
    end

    assign o_run_stop = pulse_reg[0];
    assign o_clear    = pulse_reg[1];
    assign o_mode     = pulse_reg[2];
    assign load_valid = load_valid_reg;
    assign load_value = load_value_reg;
    assign cmd_err    = err_reg;
    assign busy       = (state_reg == SET);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed protocol cases plus random byte streams,
// every cycle compared against a string-based command model.
module tb_uart_cmd_decoder;
    localparam int TMO = 50;
    localparam int VW  = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          o_run_stop, o_clear, o_mode, load_valid, cmd_err, busy;
    logic [VW-1:0] load_value;

    always #5 clk = ~clk;

    uart_cmd_decoder #(
        .MAX_DIGITS(4), .VALUE_W(VW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
        .o_run_stop(o_run_stop), .o_clear(o_clear), .o_mode(o_mode),
        .load_valid(load_valid), .load_value(load_value),
        .cmd_err(cmd_err), .busy(busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: pending digit text, last loaded value, idle edges in SET
    bit    m_in_set;
    string m_digits;
    int    m_value;
    int    m_quiet;
    bit    e_run, e_clear, e_mode, e_lv, e_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    endtask

    function automatic logic [31:0] dut_vec();
        return {12'd0, o_run_stop, o_clear, o_mode, load_valid, cmd_err, busy, load_value};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {12'd0, e_run, e_clear, e_mode, e_lv, e_err, m_in_set, VW'(m_value)};
    endfunction

    task automatic model_reset();
        m_in_set = 0; m_digits = ""; m_value = 0; m_quiet = 0;
        e_run = 0; e_clear = 0; e_mode = 0; e_lv = 0; e_err = 0;
    endtask

    task automatic model_step(input bit done, input byte c);
        e_run = 0; e_clear = 0; e_mode = 0; e_lv = 0; e_err = 0;
        if (!m_in_set) begin
            if (done) begin
                if (c == "R" || c == "r") e_run = 1;
                else if (c == "C" || c == "c") e_clear = 1;
                else if (c == "M" || c == "m") e_mode = 1;
                else if (c == "S" || c == "s") begin
                    m_in_set = 1; m_digits = ""; m_quiet = 0;
                end else if (c != 8'h0D && c != 8'h0A && c != 8'h20) e_err = 1;
            end
        end else if (done) begin
            m_quiet = 0;
            if (c >= "0" && c <= "9" && m_digits.len() < 4) begin
                m_digits = $sformatf("%s%c", m_digits, c);
            end else if ((c == 8'h0D || c == 8'h0A) && m_digits.len() > 0) begin
                m_value  = m_digits.atoi();
                e_lv     = 1;
                m_in_set = 0;
            end else begin
                e_err    = 1;
                m_in_set = 0;
            end
        end else begin
            m_quiet++;
            if (m_quiet == TMO) begin
                e_err    = 1;
                m_in_set = 0;
            end
        end
    endtask

    task automatic cycle(input bit done, input byte c);
        rx_done = done;
        rx_data = c;
        model_step(done, c);
        @(posedge clk);
        #1;
        cyc++;
        check("outputs", dut_vec(), exp_vec());
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) cycle(1'b1, s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
    endtask

    function automatic byte pick();
        int r;
        r = $urandom_range(0, 19);
        case (r)
            0, 1, 2, 3, 4, 5, 6, 7: return byte'(8'h30 + $urandom_range(0, 9));
            8:  return "S";
            9:  return "s";
            10: return 8'h0D;
            11: return 8'h0A;
            12: return "R";
            13: return "c";
            14: return "M";
            15: return " ";
            16: return byte'($urandom_range(0, 255));
            17: return "m";
            18: return "C";
            default: return "r";
        endcase
    endfunction

    initial begin
        int  n;
        bit  found;
        int  gap;

        rst = 1'b0; rx_done = 1'b0; rx_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 32'd0);
        rst = 1'b1;

        // Async reset in the middle of a set command
        send_str("S1");
        check("busy_in_set", {31'd0, busy}, 32'd1);
        rx_done = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_reset", dut_vec(), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_held", dut_vec(), 32'd0);
        rst = 1'b1;
        send_str("S7\r");
        check("load_after_reset", {18'd0, load_value}, 32'd7);

        // Single-character commands, then set commands and error cases
        send_str("RcM");
        idle(2);
        send_str("S1234\r");
        check("load_1234", {18'd0, load_value}, 32'h4D2);
        send_str("s0\n");
        check("load_0", {18'd0, load_value}, 32'd0);
        send_str("S1234\r");
        send_str("S12345");
        check("overflow_keeps_value", {18'd0, load_value}, 32'd1234);
        send_str("S\r");
        send_str("SxR");
        send_str("Z");
        send_str("S0042\r");
        check("leading_zeros", {18'd0, load_value}, 32'd42);
        send_str("RR");
        send_str(" \r\n");

        // Timeout fires on the 50th idle edge after the last byte
        send_str("S9");
        n = 0; found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            idle(1);
            n++;
            if (cmd_err) found = 1;
        end
        check("timeout_latency", n, 32'd50);
        check("busy_after_timeout", {31'd0, busy}, 32'd0);

        // A byte landing on the expiry edge wins over the timeout
        send_str("S9");
        idle(TMO - 1);
        send_str("\r");
        check("expiry_byte_wins", {18'd0, load_value}, 32'd9);

        // Random byte streams with gaps straddling the timeout boundary
        for (int t = 0; t < 400; t++) begin
            cycle(1'b1, pick());
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(TMO - 3, TMO + 3))
                                               : int'($urandom_range(0, 2));
            idle(gap);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
